// File: rtl/query_pkg.sv
// Shared constants, command-word field positions and FSM state encoding for
// the query result writer.
package query_pkg;

  localparam int CMD_W  = 128;
  localparam int DATA_W = 256;

  localparam logic [7:0] OPCODE_PAGE_WRITE = 8'h02;

  // Command word field positions
  localparam int OP_LSB   = 120;
  localparam int OP_W     = 8;
  localparam int N_LSB    = 96;
  localparam int N_W      = 16;
  localparam int BASE_LSB = 0;
  localparam int BASE_W   = 64;

  localparam int PAGE_BEATS_DEFAULT = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_RD,
    ST_CMD_LAT,
    ST_DAT_RD,
    ST_DAT_LAT,
    ST_SEND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/query_cmd_decode.sv
// Combinational field extraction and validity check for a 128-bit page command.
module query_cmd_decode
  import query_pkg::*;
#(
  parameter int PAGE_BEATS = PAGE_BEATS_DEFAULT
) (
  input  logic [CMD_W-1:0]  cmd,
  output logic [N_W-1:0]    beats,
  output logic [BASE_W-1:0] base,
  output logic              valid
);

  localparam logic [N_W-1:0] MAX_BEATS = N_W'(PAGE_BEATS);

  logic [OP_W-1:0] opcode;
  logic            unused_cmd_bits;

  assign opcode = cmd[OP_LSB +: OP_W];
  assign beats  = cmd[N_LSB +: N_W];
  assign base   = cmd[BASE_LSB +: BASE_W];

  assign valid = (opcode == OPCODE_PAGE_WRITE) && (beats != '0) && (beats <= MAX_BEATS);

  // Reserved command bits carry no meaning for this block.
  assign unused_cmd_bits = ^{cmd[OP_LSB-1:N_LSB+N_W], cmd[N_LSB-1:BASE_LSB+BASE_W]};

endmodule

// File: rtl/query_result_writer.sv
// Drains page commands and projected data beats, writing each page as a burst
// to memory. Define QUERY_RESULT_WRITER_STATS_EN to add stall/beat counters.
module query_result_writer
  import query_pkg::*;
#(
  parameter int PAGE_BEATS = PAGE_BEATS_DEFAULT,
  parameter int ADDR_W     = 64,
  parameter int BEAT_BYTES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              query_cmd_finish_fifo_empty,
  output logic              query_cmd_finish_fifo_out_en,
  input  logic [CMD_W-1:0]  query_cmd_finish_fifo_out,
  input  logic              query_data_fifo_empty,
  output logic              query_data_fifo_out_en,
  input  logic [DATA_W-1:0] query_data_fifo_out,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_last,
  output logic              page_done,
  output logic [31:0]       pages_written,
  output logic              err_bad_cmd,
  output logic              busy
`ifdef QUERY_RESULT_WRITER_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       beats_written
`endif
);

  state_t              state_q, state_d;
  logic [N_W-1:0]      cmd_beats;
  logic [BASE_W-1:0]   cmd_base;
  logic                cmd_valid;

  logic [ADDR_W-1:0]   addr_q;
  logic [N_W-1:0]      n_q;
  logic [N_W-1:0]      cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic                last_q;
  logic [31:0]         pages_q;
  logic                err_q;

  query_cmd_decode #(
    .PAGE_BEATS (PAGE_BEATS)
  ) u_decode (
    .cmd   (query_cmd_finish_fifo_out),
    .beats (cmd_beats),
    .base  (cmd_base),
    .valid (cmd_valid)
  );

  // NOTE: state and datapath registers use non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: all outputs of this block get a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d                      = state_q;
    query_cmd_finish_fifo_out_en = 1'b0;
    query_data_fifo_out_en       = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (!query_cmd_finish_fifo_empty) state_d = ST_CMD_RD;
      ST_CMD_RD: begin
        query_cmd_finish_fifo_out_en = 1'b1;
        state_d                      = ST_CMD_LAT;
      end
      ST_CMD_LAT: state_d = cmd_valid ? ST_DAT_RD : ST_IDLE;
      ST_DAT_RD: begin
        query_data_fifo_out_en = !query_data_fifo_empty;
        if (!query_data_fifo_empty) state_d = ST_DAT_LAT;
      end
      ST_DAT_LAT: state_d = ST_SEND;
      ST_SEND:    if (mem_wr_ready) state_d = last_q ? ST_DONE : ST_DAT_RD;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: the beat holding registers drive outputs directly and are therefore
  // reset, so the memory port reads all-zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      pages_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CMD_LAT: begin
          if (cmd_valid) begin
            addr_q <= ADDR_W'(cmd_base);
            n_q    <= cmd_beats;
            cnt_q  <= '0;
          end else begin
            err_q  <= 1'b1;
          end
        end
        ST_DAT_LAT: begin
          data_q <= query_data_fifo_out;
          last_q <= (cnt_q == n_q - N_W'(1));
        end
        ST_SEND: begin
          // Address wraps naturally at the top of the ADDR_W space.
          if (mem_wr_ready) begin
            cnt_q  <= cnt_q + N_W'(1);
            addr_q <= addr_q + ADDR_W'(BEAT_BYTES);
          end
        end
        ST_DONE:  pages_q <= pages_q + 32'd1;
        default: ;
      endcase
    end
  end

  assign mem_wr_valid  = (state_q == ST_SEND);
  assign page_done     = (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE);
  assign mem_wr_addr   = addr_q;
  assign mem_wr_data   = data_q;
  assign mem_wr_last   = last_q;
  assign pages_written = pages_q;
  assign err_bad_cmd   = err_q;

`ifdef QUERY_RESULT_WRITER_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] beats_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      if (((state_q == ST_SEND) && !mem_wr_ready) ||
          ((state_q == ST_DAT_RD) && query_data_fifo_empty)) begin
        if (stall_q != '1) stall_q <= stall_q + 32'd1;
      end
      if ((state_q == ST_SEND) && mem_wr_ready && (beats_q != '1)) begin
        beats_q <= beats_q + 32'd1;
      end
    end
  end

  assign stall_cycles  = stall_q;
  assign beats_written = beats_q;
`endif

endmodule

// File: tb/tb_query_result_writer.sv
// Self-checking bench: FIFO and memory models plus a page-level reference of
// expected beats built directly from each pushed command.
module tb_query_result_writer;

  typedef struct {
    logic [63:0]  addr;
    logic [255:0] data;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_empty, cmd_out_en;
  logic [127:0] cmd_dout = '0;
  logic         data_empty, data_out_en;
  logic [255:0] data_dout = '0;
  logic         mem_wr_valid, mem_wr_ready = 1'b0, mem_wr_last;
  logic [63:0]  mem_wr_addr;
  logic [255:0] mem_wr_data;
  logic         page_done, err_bad_cmd, busy;
  logic [31:0]  pages_written;
`ifdef QUERY_RESULT_WRITER_STATS_EN
  logic [31:0]  stall_cycles, beats_written;
`endif

  always #5 clk = ~clk;

  query_result_writer dut (
    .clk                          (clk),
    .rst                          (rst),
    .query_cmd_finish_fifo_empty  (cmd_empty),
    .query_cmd_finish_fifo_out_en (cmd_out_en),
    .query_cmd_finish_fifo_out    (cmd_dout),
    .query_data_fifo_empty        (data_empty),
    .query_data_fifo_out_en       (data_out_en),
    .query_data_fifo_out          (data_dout),
    .mem_wr_valid                 (mem_wr_valid),
    .mem_wr_ready                 (mem_wr_ready),
    .mem_wr_addr                  (mem_wr_addr),
    .mem_wr_data                  (mem_wr_data),
    .mem_wr_last                  (mem_wr_last),
    .page_done                    (page_done),
    .pages_written                (pages_written),
    .err_bad_cmd                  (err_bad_cmd),
    .busy                         (busy)
`ifdef QUERY_RESULT_WRITER_STATS_EN
    ,
    .stall_cycles                 (stall_cycles),
    .beats_written                (beats_written)
`endif
  );

  // FIFO storage: write side owned by the stimulus, read side by the FIFO model
  logic [127:0] cmd_mem  [0:255];
  logic [255:0] data_mem [0:4095];
  logic [255:0] pend_mem [0:4095];
  int c_wr = 0, c_rd = 0, d_wr = 0, d_rd = 0, p_wr = 0, p_rd = 0;
  int rd_cnt = 0;

  // Reference and observation records
  beat_t exp_mem [0:2047];
  beat_t obs_mem [0:2047];
  int exp_cnt = 0, obs_cnt = 0, exp_pages = 0;
  bit exp_err = 1'b0;
  int uf_cnt = 0, stab_err = 0, wait_cnt = 0, valid_cyc = 0, done_cnt = 0;
  int obs_at_reset = 0;

  int n_pass = 0, n_total = 0;
  int ready_mode = 0, stall_at = -1, stall_len = 0;

  logic rd_cmd_s = 1'b0, rd_data_s = 1'b0;

  assign cmd_empty  = (c_rd == c_wr);
  assign data_empty = (d_rd == d_wr);

  // Monitor: samples everything on the falling edge
  bit           hold_prev = 1'b0;
  logic [63:0]  p_addr;
  logic [255:0] p_data;
  logic         p_last;
  always @(negedge clk) begin
    rd_cmd_s  = cmd_out_en;
    rd_data_s = data_out_en;
    if ((data_out_en && data_empty) || (cmd_out_en && cmd_empty)) uf_cnt++;
    if (!rst) begin
      hold_prev    = 1'b0;
      obs_at_reset = obs_cnt;
    end else begin
      if (hold_prev && (!mem_wr_valid || mem_wr_addr !== p_addr ||
                        mem_wr_data !== p_data || mem_wr_last !== p_last)) stab_err++;
      if (mem_wr_valid && !mem_wr_ready) wait_cnt++;
      if (mem_wr_valid) valid_cyc++;
      if (mem_wr_valid && mem_wr_ready) begin
        obs_mem[obs_cnt] = '{addr: mem_wr_addr, data: mem_wr_data, last: mem_wr_last};
        obs_cnt++;
      end
      if (page_done) done_cnt++;
      hold_prev = mem_wr_valid && !mem_wr_ready;
      p_addr = mem_wr_addr;
      p_data = mem_wr_data;
      p_last = mem_wr_last;
    end
  end

  // Standard FIFO read side: dout updates shortly after the edge that saw out_en
  always @(posedge clk) begin
    bit do_c, do_d;
    do_c = rd_cmd_s;
    do_d = rd_data_s;
    #1;
    if (!rst) begin
      c_rd = c_wr;
      d_rd = d_wr;
    end else begin
      if (do_c && c_rd != c_wr) begin
        cmd_dout = cmd_mem[c_rd % 256];
        c_rd++;
      end
      if (do_d && d_rd != d_wr) begin
        data_dout = data_mem[d_rd % 4096];
        d_rd++;
        rd_cnt++;
      end
    end
  end

  // Memory ready driver: 0 = always ready, 1 = random, 2 = stall beat stall_at
  int stall_run = 0;
  always @(posedge clk) begin
    #1;
    if (obs_cnt != stall_at) stall_run = 0;
    case (ready_mode)
      1: mem_wr_ready = 1'($urandom_range(0, 1));
      2: begin
        if (mem_wr_valid && obs_cnt == stall_at && stall_run < stall_len) begin
          mem_wr_ready = 1'b0;
          stall_run++;
        end else begin
          mem_wr_ready = 1'b1;
        end
      end
      default: mem_wr_ready = 1'b1;
    endcase
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Queue a command; if it is a legal page, reserve its data and expected beats
  task automatic push_cmd(input logic [7:0] op, input logic [15:0] n, input logic [63:0] base);
    logic [127:0] w;
    logic [255:0] d;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[127:120] = op;
    w[111:96]  = n;
    w[63:0]    = base;
    cmd_mem[c_wr % 256] = w;
    c_wr++;
    if (op == 8'h02 && n >= 16'd1 && n <= 16'd128) begin
      for (int i = 0; i < int'(n); i++) begin
        d = rand256();
        pend_mem[p_wr % 4096] = d;
        p_wr++;
        exp_mem[exp_cnt] = '{addr: base + 64'(32 * i), data: d, last: (i == int'(n) - 1)};
        exp_cnt++;
      end
      exp_pages++;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic push_data(input int k);
    for (int i = 0; i < k; i++) begin
      data_mem[d_wr % 4096] = pend_mem[p_rd % 4096];
      d_wr++;
      p_rd++;
    end
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (obs_cnt - obs_at_reset >= 0 && cmd_empty && !busy && p_rd == p_wr && data_empty) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int first_diff(input int ob, input int eb, input int n);
    for (int i = 0; i < n; i++) begin
      if (obs_mem[ob + i].addr !== exp_mem[eb + i].addr ||
          obs_mem[ob + i].data !== exp_mem[eb + i].data ||
          obs_mem[ob + i].last !== exp_mem[eb + i].last) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({mem_wr_valid, mem_wr_last, page_done, err_bad_cmd, busy, cmd_out_en, data_out_en} !== 7'b0)
      $display("FAIL reset_flags: got %b want 0", {mem_wr_valid, mem_wr_last, page_done, err_bad_cmd, busy, cmd_out_en, data_out_en});
    else n_pass++;
    n_total++;
    if (mem_wr_addr !== 64'h0 || mem_wr_data !== 256'h0)
      $display("FAIL reset_addr_data: got addr=%h data=%h want 0", mem_wr_addr, mem_wr_data);
    else n_pass++;
    n_total++;
    if (pages_written !== 32'd0) $display("FAIL reset_pages: got %0d want 0", pages_written);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_single_page();
    int ob, eb, rb, db, idx;
    bit ok;
    ready_mode = 0;
    @(posedge clk);
    #1;
    ob = obs_cnt; eb = exp_cnt; rb = rd_cnt; db = done_cnt;
    push_cmd(8'h02, 16'd4, 64'h1000);
    push_data(4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (mem_wr_valid !== 1'b0) $display("FAIL latency_early: got valid=%b want 0", mem_wr_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 64'h1000)
      $display("FAIL latency: got valid=%b addr=%h want 1/1000", mem_wr_valid, mem_wr_addr);
    else n_pass++;
    wait_done(200, ok);
    n_total++;
    if (!ok) $display("FAIL single_timeout: got busy=%b want idle", busy);
    else n_pass++;
    idx = first_diff(ob, eb, 4);
    n_total++;
    if (obs_cnt - ob !== 4 || idx !== -1)
      $display("FAIL single_beats: got %0d beats, first diff %0d want 4 beats, -1", obs_cnt - ob, idx);
    else n_pass++;
    n_total++;
    if (obs_mem[ob + 3].addr !== 64'h1060 || obs_mem[ob + 3].last !== 1'b1 || obs_mem[ob + 2].last !== 1'b0)
      $display("FAIL single_last: got addr=%h last=%b want 1060/1", obs_mem[ob + 3].addr, obs_mem[ob + 3].last);
    else n_pass++;
    n_total++;
    if (rd_cnt - rb !== 4 || done_cnt - db !== 1 || pages_written !== 32'(exp_pages))
      $display("FAIL single_counts: got reads=%0d done=%0d pages=%0d want 4/1/%0d",
               rd_cnt - rb, done_cnt - db, pages_written, exp_pages);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int ob, eb, rb, sb, wb, idx;
    bit ok;
    ob = obs_cnt; eb = exp_cnt; rb = rd_cnt; sb = stab_err; wb = wait_cnt;
    stall_at = obs_cnt + 1;
    stall_len = 3;
    ready_mode = 2;
    push_cmd(8'h02, 16'd4, {32'h0, $urandom} & ~64'h1f);
    push_data(4);
    wait_done(200, ok);
    ready_mode = 0;
    idx = first_diff(ob, eb, 4);
    n_total++;
    if (!ok || obs_cnt - ob !== 4 || idx !== -1)
      $display("FAIL bp_beats: got ok=%b beats=%0d diff=%0d want 1/4/-1", ok, obs_cnt - ob, idx);
    else n_pass++;
    n_total++;
    if (wait_cnt - wb !== 3 || stab_err - sb !== 0)
      $display("FAIL bp_hold: got stalls=%0d unstable=%0d want 3/0", wait_cnt - wb, stab_err - sb);
    else n_pass++;
    n_total++;
    if (rd_cnt - rb !== 4) $display("FAIL bp_reads: got %0d want 4", rd_cnt - rb);
    else n_pass++;
  endtask

  task automatic test_bad_cmd();
    int ob, eb, rb, vb, idx;
    bit ok;
    n_total++;
    if (err_bad_cmd !== 1'b0) $display("FAIL err_initial: got %b want 0", err_bad_cmd);
    else n_pass++;
    ob = obs_cnt; rb = rd_cnt; vb = valid_cyc;
    push_cmd(8'h03, 16'd4, 64'h2000);
    push_cmd(8'h02, 16'd0, 64'h3000);
    push_cmd(8'h02, 16'd129, 64'h4000);
    wait_done(200, ok);
    n_total++;
    if (!ok || err_bad_cmd !== 1'b1) $display("FAIL err_set: got ok=%b err=%b want 1/1", ok, err_bad_cmd);
    else n_pass++;
    n_total++;
    if (rd_cnt - rb !== 0 || valid_cyc - vb !== 0)
      $display("FAIL bad_no_activity: got reads=%0d valid_cycles=%0d want 0/0", rd_cnt - rb, valid_cyc - vb);
    else n_pass++;
    eb = exp_cnt;
    push_cmd(8'h02, 16'd2, 64'h5000);
    push_cmd(8'h02, 16'd128, 64'h8000);
    push_data(130);
    wait_done(1000, ok);
    idx = first_diff(ob, eb, 130);
    n_total++;
    if (!ok || obs_cnt - ob !== 130 || idx !== -1)
      $display("FAIL bad_then_good: got ok=%b beats=%0d diff=%0d want 1/130/-1", ok, obs_cnt - ob, idx);
    else n_pass++;
    n_total++;
    if (err_bad_cmd !== 1'b1 || pages_written !== 32'(exp_pages))
      $display("FAIL bad_sticky: got err=%b pages=%0d want 1/%0d", err_bad_cmd, pages_written, exp_pages);
    else n_pass++;
  endtask

  task automatic test_starvation();
    int ob, eb, ub, idx;
    bit ok, got1;
    ob = obs_cnt; eb = exp_cnt; ub = uf_cnt;
    push_cmd(8'h02, 16'd3, 64'h9000);
    push_data(1);
    got1 = 1'b0;
    for (int i = 0; i < 50 && !got1; i++) begin
      @(negedge clk);
      if (obs_cnt - ob == 1) got1 = 1'b1;
    end
    repeat (10) @(negedge clk);
    n_total++;
    if (!got1 || obs_cnt - ob !== 1 || busy !== 1'b1 || data_out_en !== 1'b0)
      $display("FAIL starve_wait: got beats=%0d busy=%b out_en=%b want 1/1/0", obs_cnt - ob, busy, data_out_en);
    else n_pass++;
    @(posedge clk);
    #1;
    push_data(2);
    wait_done(200, ok);
    idx = first_diff(ob, eb, 3);
    n_total++;
    if (!ok || obs_cnt - ob !== 3 || idx !== -1)
      $display("FAIL starve_resume: got ok=%b beats=%0d diff=%0d want 1/3/-1", ok, obs_cnt - ob, idx);
    else n_pass++;
    n_total++;
    if (uf_cnt - ub !== 0) $display("FAIL starve_underflow: got %0d empty reads want 0", uf_cnt - ub);
    else n_pass++;
  endtask

  task automatic test_reset_mid_page();
    int ob, eb, idx, n;
    bit ok, found;
    stall_at = obs_cnt + 1;
    stall_len = 1000;
    ready_mode = 2;
    push_cmd(8'h02, 16'd8, 64'hA000);
    push_data(8);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (obs_cnt == stall_at && mem_wr_valid) found = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    exp_pages = 0;
    exp_err = 1'b0;
    @(negedge clk);
    n_total++;
    if (!found || {mem_wr_valid, mem_wr_last, page_done, err_bad_cmd, busy, cmd_out_en, data_out_en} !== 7'b0 ||
        mem_wr_addr !== 64'h0 || mem_wr_data !== 256'h0 || pages_written !== 32'd0)
      $display("FAIL midreset_outputs: got found=%b valid=%b busy=%b addr=%h pages=%0d want 1/0/0/0/0",
               found, mem_wr_valid, busy, mem_wr_addr, pages_written);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    ob = obs_cnt; eb = exp_cnt;
    n = $urandom_range(1, 8);
    push_cmd(8'h02, 16'(n), {$urandom, $urandom});
    push_data(n);
    wait_done(300, ok);
    idx = first_diff(ob, eb, n);
    n_total++;
    if (!ok || obs_cnt - ob !== n || idx !== -1 || pages_written !== 32'd1)
      $display("FAIL midreset_restart: got beats=%0d diff=%0d pages=%0d want %0d/-1/1",
               obs_cnt - ob, idx, pages_written, n);
    else n_pass++;
  endtask

  task automatic test_addr_wrap();
    int ob, eb, idx;
    bit ok;
    ob = obs_cnt; eb = exp_cnt;
    push_cmd(8'h02, 16'd2, 64'hFFFF_FFFF_FFFF_FFE0);
    push_data(2);
    wait_done(100, ok);
    idx = first_diff(ob, eb, 2);
    n_total++;
    if (!ok || obs_cnt - ob !== 2 || idx !== -1 || obs_mem[ob + 1].addr !== 64'h0)
      $display("FAIL addr_wrap: got beats=%0d second_addr=%h want 2/0", obs_cnt - ob, obs_mem[ob + 1].addr);
    else n_pass++;
  endtask

  task automatic test_random();
    int ob, eb, rb, ub, sb, idx, kind;
    logic [7:0] op;
    logic [15:0] n;
    bit ok;
    ob = obs_cnt; eb = exp_cnt; rb = rd_cnt; ub = uf_cnt; sb = stab_err;
    ready_mode = 1;
    for (int c = 0; c < 12; c++) begin
      kind = $urandom_range(0, 9);
      op = 8'h02;
      n = 16'($urandom_range(1, 12));
      if (kind == 0) begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h02) op = 8'h82;
      end else if (kind == 1) begin
        n = 16'd0;
      end else if (kind == 2) begin
        n = 16'($urandom_range(129, 65535));
      end
      push_cmd(op, n, {$urandom, $urandom});
    end
    push_data(p_wr - p_rd);
    wait_done(5000, ok);
    ready_mode = 0;
    idx = first_diff(ob, eb, exp_cnt - eb);
    n_total++;
    if (!ok || obs_cnt - ob !== exp_cnt - eb || idx !== -1)
      $display("FAIL random_beats: got ok=%b beats=%0d diff=%0d want 1/%0d/-1", ok, obs_cnt - ob, idx, exp_cnt - eb);
    else n_pass++;
    n_total++;
    if (pages_written !== 32'(exp_pages) || err_bad_cmd !== exp_err)
      $display("FAIL random_status: got pages=%0d err=%b want %0d/%b", pages_written, err_bad_cmd, exp_pages, exp_err);
    else n_pass++;
    n_total++;
    if (rd_cnt - rb !== exp_cnt - eb || uf_cnt - ub !== 0 || stab_err - sb !== 0)
      $display("FAIL random_protocol: got reads=%0d underflow=%0d unstable=%0d want %0d/0/0",
               rd_cnt - rb, uf_cnt - ub, stab_err - sb, exp_cnt - eb);
    else n_pass++;
`ifdef QUERY_RESULT_WRITER_STATS_EN
    n_total++;
    if (beats_written !== 32'(obs_cnt - obs_at_reset))
      $display("FAIL stats_beats: got %0d want %0d", beats_written, obs_cnt - obs_at_reset);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_page();
    test_backpressure();
    test_bad_cmd();
    test_starvation();
    test_reset_mid_page();
    test_addr_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/query_result_writer.md
Name: query_result_writer

Overview:
- Downstream of data_projector. Drains its 128-bit page-finish command FIFO and its 256-bit projected-data FIFO.
- For each page command, writes a burst of 256-bit beats to the memory write port at consecutive addresses, then reports page completion.
- One page command at a time. FIFOs are standard (non-FWFT): dout is valid on the cycle after rd_en.

Parameters:
- PAGE_BEATS, 128, max beats per page (4 KB of 256-bit beats)
- ADDR_W, 64, memory byte-address width
- BEAT_BYTES, 32, address increment per beat

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- query_cmd_finish_fifo_empty  in  1  command FIFO empty
- query_cmd_finish_fifo_out_en  out  1  command FIFO read strobe
- query_cmd_finish_fifo_out  in  128  command word
- query_data_fifo_empty  in  1  data FIFO empty
- query_data_fifo_out_en  out  1  data FIFO read strobe
- query_data_fifo_out  in  256  data beat
- mem_wr_valid  out  1  write beat valid
- mem_wr_ready  in  1  memory accepts beat
- mem_wr_addr  out  ADDR_W  beat byte address
- mem_wr_data  out  256  beat data
- mem_wr_last  out  1  final beat of page
- page_done  out  1  one-cycle pulse per completed page
- pages_written  out  32  completed-page count
- err_bad_cmd  out  1  sticky; set by any rejected command
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; holding registers 0.
- Command word layout:
  - [127:120] opcode; 8'h02 = PAGE_WRITE.
  - [111:96] beat count N.
  - [63:0] base byte address.
  - All other bits are ignored.
- States:
  - IDLE: if cmd FIFO is not empty, go to CMD_RD.
  - CMD_RD: cmd out_en=1 for exactly one cycle; go to CMD_LAT.
  - CMD_LAT: latch the command. Validate opcode==8'h02 and 1<=N<=PAGE_BEATS.
    - Invalid: set err_bad_cmd, consume no data, go to IDLE.
    - Valid: load addr=base, beat_cnt=0, go to DAT_RD.
  - DAT_RD: data out_en = !query_data_fifo_empty, combinational and only in this state. Leave for DAT_LAT when out_en=1; otherwise stay.
  - DAT_LAT: capture dout into mem_wr_data. mem_wr_last = (beat_cnt==N-1). Go to SEND.
  - SEND: mem_wr_valid=1. addr, data and last are held stable until mem_wr_ready. On ready: beat_cnt+1, addr+BEAT_BYTES (wraps mod 2^ADDR_W). Then go to DONE if last, else DAT_RD.
  - DONE: page_done=1 for one cycle, pages_written+1 (wraps 2^32-1 -> 0). Go to IDLE.
- mem_wr_valid is asserted only in SEND. It never drops before ready. Ready while valid is low is ignored.
- Latency: cmd FIFO non-empty in IDLE at edge 0, data FIFO non-empty -> mem_wr_valid high after edge 4. Throughput is at most one beat per 3 cycles.
- Data FIFO empty mid-page: wait in DAT_RD; no timeout.
- Reading a FIFO while empty is never permitted.
- A command arriving while busy stays queued until IDLE.
- Reset mid-page: the page is abandoned immediately and no further beats are driven. pages_written and err_bad_cmd are cleared.

Optional Feature:
- Macro: QUERY_RESULT_WRITER_STATS_EN.
- When defined, two extra output ports are added:
  - stall_cycles[31:0]: increments each cycle in SEND with mem_wr_ready=0, or in DAT_RD with data FIFO empty.
  - beats_written[31:0]: increments per accepted beat.
  - Both are saturating and reset to 0.
- When not defined, these ports and their counters do not exist. All other behaviour is identical.

Decomposition:
- Package query_pkg holds:
  - OPCODE_PAGE_WRITE=8'h02
  - command field bit positions
  - PAGE_BEATS default
  - state enum
- One sub-module, query_cmd_decode: combinational extraction of fields and the valid flag from the 128-bit command.

Test Plan:
- Single page: cmd {op=02,N=4,base=0x1000}, data preloaded, ready=1 -> 4 beats at 0x1000/0x1020/0x1040/0x1060, last on 4th beat, page_done once, pages_written=1.
- Backpressure: ready low 3 cycles on beat 2 -> addr/data/last held stable, no extra data FIFO read, beat sequence unchanged.
- Bad command: op=03, or N=0, or N=129 -> err_bad_cmd=1, zero data reads, no mem_wr_valid; a following valid command still completes.
- Data starvation: data FIFO empty after beat 1 of N=3 -> out_en never asserted while empty; resumes when data arrives; 3 beats total.
- Reset mid-page: rst low during beat 2 of N=8 -> all outputs 0 next cycle; after release, a new command starts from its own base.
- Address wrap: base=0xFFFF_FFFF_FFFF_FFE0, N=2 -> second beat at address 0x0.
